// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Brief    : Memory-access stage plus MEM/WB pipeline register. Issues
//            handshaked load/store requests, stalls upstream until each
//            access is acknowledged, and drives the MEM/WB fields consumed
//            by the EX-stage forwarding logic.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    // EX/MEM side
    input  logic            EX_MEM_Valid,
    input  logic            EX_MEM_RegWrite,
    input  logic            EX_MEM_MemRead,
    input  logic            EX_MEM_MemWrite,
    input  logic [RA_W-1:0] EX_MEM_RegisterRd,
    input  logic [XLEN-1:0] EX_MEM_ALUOut,
    input  logic [XLEN-1:0] EX_MEM_StoreData,
    input  logic            flush,
    // Data memory handshake
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    // Pipeline control
    output logic            stall,
    // MEM/WB register
    output logic            MEM_WB_Valid,
    output logic            MEM_WB_RegWrite,
    output logic            MEM_WB_MemRead,
    output logic [RA_W-1:0] MEM_WB_RegisterRd,
    output logic [XLEN-1:0] MEM_WB_ALUOut,
    output logic [XLEN-1:0] MEM_WB_MemOut
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] C_IDLE   = 1'b0;
    localparam logic [0:0] C_ACCESS = 1'b1;

    logic [0:0]      r_state;

    // Access request registers (held stable for the whole access)
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;

    // Controls of the instruction whose access is in flight
    logic [RA_W-1:0] r_hold_rd;
    logic            r_hold_regwrite;
    logic            r_hold_memread;

    // MEM/WB pipeline register
    logic            r_wb_valid;
    logic            r_wb_regwrite;
    logic            r_wb_memread;
    logic [RA_W-1:0] r_wb_rd;
    logic [XLEN-1:0] r_wb_aluout;
    logic [XLEN-1:0] r_wb_memout;

    // ------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------
    logic w_in_valid;
    logic w_mem_op;
    logic w_is_store;
    logic w_rd_nonzero;
    logic w_in_idle;
    logic w_ack_done;

    assign w_in_valid   = EX_MEM_Valid & ~flush;
    assign w_mem_op     = w_in_valid & (EX_MEM_MemRead | EX_MEM_MemWrite);
    // Read+write together is illegal; it is resolved as a load.
    assign w_is_store   = EX_MEM_MemWrite & ~EX_MEM_MemRead;
    assign w_rd_nonzero = (EX_MEM_RegisterRd != '0);
    assign w_in_idle    = (r_state == C_IDLE);
    // An ack is meaningful only while an access is outstanding.
    assign w_ack_done   = (r_state == C_ACCESS) & mem_ack;

    // Stall is a pure function of state, inputs and ack (never of MEM/WB)
    always_comb begin
        stall = 1'b0;
        if (w_in_idle) begin
            stall = w_mem_op;
        end else begin
            stall = ~mem_ack;
        end
    end

    // Access sequencer: latch the request in IDLE, hold it until ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= C_IDLE;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_hold_rd       <= '0;
            r_hold_regwrite <= 1'b0;
            r_hold_memread  <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_mem_op) begin
                        r_state         <= C_ACCESS;
                        r_mem_req       <= 1'b1;
                        r_mem_we        <= w_is_store;
                        r_mem_addr      <= EX_MEM_ALUOut;
                        r_mem_wdata     <= EX_MEM_StoreData;
                        r_hold_rd       <= EX_MEM_RegisterRd;
                        // Stores never write the register file.
                        r_hold_regwrite <= EX_MEM_RegWrite & ~w_is_store & w_rd_nonzero;
                        r_hold_memread  <= ~w_is_store;
                    end
                end
                C_ACCESS: begin
                    // flush is deliberately ignored here: the access runs to completion.
                    if (mem_ack) begin
                        r_state   <= C_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= C_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register: pass-through in IDLE, bubbles while waiting, writeback on ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_memread  <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_aluout   <= '0;
            r_wb_memout   <= '0;
        end else if (w_in_idle) begin
            if (w_mem_op) begin
                // Memory op just launched: nothing retires this cycle.
                r_wb_valid    <= 1'b0;
                r_wb_regwrite <= 1'b0;
                r_wb_memread  <= 1'b0;
            end else begin
                r_wb_valid    <= w_in_valid;
                r_wb_regwrite <= w_in_valid & EX_MEM_RegWrite & w_rd_nonzero;
                r_wb_memread  <= 1'b0;
                r_wb_rd       <= EX_MEM_RegisterRd;
                r_wb_aluout   <= EX_MEM_ALUOut;
            end
        end else if (w_ack_done) begin
            r_wb_valid    <= 1'b1;
            r_wb_regwrite <= r_hold_regwrite;
            r_wb_memread  <= r_hold_memread;
            r_wb_rd       <= r_hold_rd;
            r_wb_aluout   <= r_mem_addr;
            // Stores keep the last load result visible.
            if (r_hold_memread) begin
                r_wb_memout <= mem_rdata;
            end
        end else begin
            r_wb_valid    <= 1'b0;
            r_wb_regwrite <= 1'b0;
            r_wb_memread  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign mem_req           = r_mem_req;
    assign mem_we            = r_mem_we;
    assign mem_addr          = r_mem_addr;
    assign mem_wdata         = r_mem_wdata;
    assign MEM_WB_Valid      = r_wb_valid;
    assign MEM_WB_RegWrite   = r_wb_regwrite;
    assign MEM_WB_MemRead    = r_wb_memread;
    assign MEM_WB_RegisterRd = r_wb_rd;
    assign MEM_WB_ALUOut     = r_wb_aluout;
    assign MEM_WB_MemOut     = r_wb_memout;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Scoreboard bench for mem_wb_stage. Directed instructions push
//            hand-computed writebacks; a monitor pops them on MEM_WB_Valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            EX_MEM_Valid, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
    logic [RA_W-1:0] EX_MEM_RegisterRd;
    logic [XLEN-1:0] EX_MEM_ALUOut, EX_MEM_StoreData;
    logic            flush;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;
    logic            mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            stall;
    logic            MEM_WB_Valid, MEM_WB_RegWrite, MEM_WB_MemRead;
    logic [RA_W-1:0] MEM_WB_RegisterRd;
    logic [XLEN-1:0] MEM_WB_ALUOut, MEM_WB_MemOut;

    mem_wb_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .EX_MEM_Valid      (EX_MEM_Valid),
        .EX_MEM_RegWrite   (EX_MEM_RegWrite),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_MemWrite   (EX_MEM_MemWrite),
        .EX_MEM_RegisterRd (EX_MEM_RegisterRd),
        .EX_MEM_ALUOut     (EX_MEM_ALUOut),
        .EX_MEM_StoreData  (EX_MEM_StoreData),
        .flush             (flush),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .stall             (stall),
        .MEM_WB_Valid      (MEM_WB_Valid),
        .MEM_WB_RegWrite   (MEM_WB_RegWrite),
        .MEM_WB_MemRead    (MEM_WB_MemRead),
        .MEM_WB_RegisterRd (MEM_WB_RegisterRd),
        .MEM_WB_ALUOut     (MEM_WB_ALUOut),
        .MEM_WB_MemOut     (MEM_WB_MemOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RA_W-1:0] rd;
        logic            rw;
        logic            mr;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] mout;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model controls
    int              ack_delay = 1;
    int              mem_cnt   = 0;
    logic [XLEN-1:0] ack_rdata = '0;
    logic [XLEN-1:0] exp_addr  = '0;
    logic [XLEN-1:0] exp_wdata = '0;
    logic            exp_we    = 1'b0;
    bit              mem_auto  = 1'b1;
    bit              force_ack = 1'b0;

    int sc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [RA_W-1:0] rd, input logic rw, input logic mr,
                            input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mout);
        exp_t e;
        e.rd = rd; e.rw = rw; e.mr = mr; e.alu = alu; e.mout = mout;
        sb_q.push_back(e);
    endtask

    task automatic drive_idle();
        EX_MEM_Valid      = 1'b0;
        EX_MEM_RegWrite   = 1'b0;
        EX_MEM_MemRead    = 1'b0;
        EX_MEM_MemWrite   = 1'b0;
        EX_MEM_RegisterRd = '0;
        EX_MEM_ALUOut     = '0;
        EX_MEM_StoreData  = '0;
        flush             = 1'b0;
    endtask

    // Present one instruction (called at posedge+1) and hold it while stall is high.
    task automatic issue(input logic ld, input logic st, input logic rw,
                         input logic [RA_W-1:0] rd, input logic [XLEN-1:0] alu,
                         input logic [XLEN-1:0] sd, input logic fl, input logic late_fl,
                         output int stall_cyc);
        int guard = 0;
        bit first = 1'b1;
        EX_MEM_Valid      = 1'b1;
        EX_MEM_RegWrite   = rw;
        EX_MEM_MemRead    = ld;
        EX_MEM_MemWrite   = st;
        EX_MEM_RegisterRd = rd;
        EX_MEM_ALUOut     = alu;
        EX_MEM_StoreData  = sd;
        flush             = fl;
        stall_cyc         = 0;
        forever begin
            @(negedge clk);
            if (first && (ld || st) && !fl) check("req_low_in_idle", {31'b0, mem_req}, 32'd0);
            if (!first) begin
                check("req_held", {31'b0, mem_req}, 32'd1);
                check("wb_bubble", {31'b0, MEM_WB_Valid}, 32'd0);
            end
            if (!stall) break;
            stall_cyc++;
            guard++;
            if (guard > 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL stall_timeout: stall still 1 after %0d cycles, expected release", guard);
                break;
            end
            @(posedge clk); #1;
            if (first && late_fl) flush = 1'b1;
            first = 1'b0;
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    // Handshaking data memory: acks ack_delay cycles after req is seen
    initial begin : mem_model
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
            if (!mem_auto) begin
                mem_cnt   = 0;
                mem_ack   = force_ack;
                mem_rdata = ack_rdata;
            end else if (rst || !mem_req) begin
                mem_cnt = 0;
            end else begin
                mem_cnt++;
                if (mem_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ack_rdata;
                    mem_cnt   = 0;
                    check("mem_addr",  mem_addr, exp_addr);
                    check("mem_we",    {31'b0, mem_we}, {31'b0, exp_we});
                    check("mem_wdata", mem_wdata, exp_wdata);
                end
            end
        end
    end

    // Scoreboard monitor: every valid MEM/WB beat must match the next expectation
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && MEM_WB_Valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_wb: rd=%0d alu=%h, expected no writeback", MEM_WB_RegisterRd, MEM_WB_ALUOut);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("wb_rd",       {27'b0, MEM_WB_RegisterRd}, {27'b0, mon_e.rd});
                    check("wb_regwrite", {31'b0, MEM_WB_RegWrite}, {31'b0, mon_e.rw});
                    check("wb_memread",  {31'b0, MEM_WB_MemRead}, {31'b0, mon_e.mr});
                    check("wb_aluout",   MEM_WB_ALUOut, mon_e.alu);
                    check("wb_memout",   MEM_WB_MemOut, mon_e.mout);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1;
        drive_idle();
        #12;
        // Reset state
        check("rst_mem_req",   {31'b0, mem_req}, 32'd0);
        check("rst_mem_we",    {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_stall",     {31'b0, stall}, 32'd0);
        check("rst_wb_valid",  {31'b0, MEM_WB_Valid}, 32'd0);
        check("rst_wb_rw",     {31'b0, MEM_WB_RegWrite}, 32'd0);
        check("rst_wb_mr",     {31'b0, MEM_WB_MemRead}, 32'd0);
        check("rst_wb_rd",     {27'b0, MEM_WB_RegisterRd}, 32'd0);
        check("rst_wb_alu",    MEM_WB_ALUOut, 32'd0);
        check("rst_wb_mout",   MEM_WB_MemOut, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Three ALU ops, rd 5/6/0: rd 0 must not write back
        push_exp(5'd5, 1'b1, 1'b0, 32'h11, 32'h0);
        issue(1'b0, 1'b0, 1'b1, 5'd5, 32'h11, 32'h0, 1'b0, 1'b0, sc);
        check("alu5_stall", sc, 32'd0);
        push_exp(5'd6, 1'b1, 1'b0, 32'h22, 32'h0);
        issue(1'b0, 1'b0, 1'b1, 5'd6, 32'h22, 32'h0, 1'b0, 1'b0, sc);
        check("alu6_stall", sc, 32'd0);
        push_exp(5'd0, 1'b0, 1'b0, 32'h33, 32'h0);
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h33, 32'h0, 1'b0, 1'b0, sc);
        check("alu0_stall", sc, 32'd0);

        // Load 0x100 -> rd 7, ack 3 cycles after req
        ack_delay = 3; ack_rdata = 32'hDEAD_BEEF;
        exp_addr = 32'h100; exp_we = 1'b0; exp_wdata = 32'h0;
        push_exp(5'd7, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0, 1'b0, 1'b0, sc);
        check("load_stall", sc, 32'd3);

        // Store 0x55 to 0x20, ack in first ACCESS cycle; RegWrite forced off
        ack_delay = 1; ack_rdata = 32'hCAFE_0000;
        exp_addr = 32'h20; exp_we = 1'b1; exp_wdata = 32'h55;
        push_exp(5'd9, 1'b0, 1'b0, 32'h20, 32'hDEAD_BEEF);
        issue(1'b0, 1'b1, 1'b1, 5'd9, 32'h20, 32'h55, 1'b0, 1'b0, sc);
        check("store_stall", sc, 32'd1);

        // Load flushed in IDLE: no request, no stall, bubble
        issue(1'b1, 1'b0, 1'b1, 5'd8, 32'h300, 32'h0, 1'b1, 1'b0, sc);
        check("flush_idle_stall", sc, 32'd0);
        check("flush_idle_req", {31'b0, mem_req}, 32'd0);
        check("flush_idle_wb", {31'b0, MEM_WB_Valid}, 32'd0);

        // flush raised during ACCESS is ignored
        ack_delay = 2; ack_rdata = 32'h1234_5678;
        exp_addr = 32'h40; exp_we = 1'b0; exp_wdata = 32'h0;
        push_exp(5'd10, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
        issue(1'b1, 1'b0, 1'b1, 5'd10, 32'h40, 32'h0, 1'b0, 1'b1, sc);
        check("flush_acc_stall", sc, 32'd2);

        // Back-to-back loads rd 3 then rd 4
        ack_delay = 1; ack_rdata = 32'hA5A5_A5A5;
        exp_addr = 32'h80; exp_we = 1'b0; exp_wdata = 32'h0;
        push_exp(5'd3, 1'b1, 1'b1, 32'h80, 32'hA5A5_A5A5);
        issue(1'b1, 1'b0, 1'b1, 5'd3, 32'h80, 32'h0, 1'b0, 1'b0, sc);
        check("b2b_1_stall", sc, 32'd1);
        ack_rdata = 32'h5A5A_5A5A; exp_addr = 32'h84;
        push_exp(5'd4, 1'b1, 1'b1, 32'h84, 32'h5A5A_5A5A);
        issue(1'b1, 1'b0, 1'b1, 5'd4, 32'h84, 32'h0, 1'b0, 1'b0, sc);
        check("b2b_2_stall", sc, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);

        // Reset during ACCESS, then a late ack must be ignored
        mem_auto = 1'b0; force_ack = 1'b0; ack_rdata = 32'hFEED_FACE;
        EX_MEM_Valid = 1'b1; EX_MEM_RegWrite = 1'b1; EX_MEM_MemRead = 1'b1;
        EX_MEM_RegisterRd = 5'd11; EX_MEM_ALUOut = 32'h200;
        @(posedge clk); #1;
        check("rst_acc_req_before", {31'b0, mem_req}, 32'd1);
        drive_idle();
        rst = 1'b1;
        #1;
        check("rst_acc_req",   {31'b0, mem_req}, 32'd0);
        check("rst_acc_addr",  mem_addr, 32'd0);
        check("rst_acc_stall", {31'b0, stall}, 32'd0);
        check("rst_acc_mout",  MEM_WB_MemOut, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_wb",  {31'b0, MEM_WB_Valid}, 32'd0);
            check("late_ack_rw",  {31'b0, MEM_WB_RegWrite}, 32'd0);
            check("late_ack_req", {31'b0, mem_req}, 32'd0);
        end

        // Recovery: an ALU op flows normally; MemOut is back to 0
        mem_auto = 1'b1;
        @(posedge clk); #1;
        push_exp(5'd12, 1'b1, 1'b0, 32'h77, 32'h0);
        issue(1'b0, 1'b0, 1'b1, 5'd12, 32'h77, 32'h0, 1'b0, 1'b0, sc);
        check("recover_stall", sc, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("sb_final_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Producer end of the writeback-forwarding interface: memory-access stage plus MEM/WB pipeline register.
- Generates MEM_WB_RegWrite, MEM_WB_MemRead, MEM_WB_RegisterRd and the two result buses that the forwarding logic in EX consumes.
- Sequences load/store requests to a handshaked data memory and stalls the upstream pipeline until each access completes.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
EX_MEM_Valid  in  1  EX/MEM holds a real instruction
EX_MEM_RegWrite  in  1  instruction writes rd
EX_MEM_MemRead  in  1  load
EX_MEM_MemWrite  in  1  store
EX_MEM_RegisterRd  in  RA_W  destination register
EX_MEM_ALUOut  in  XLEN  ALU result / memory address
EX_MEM_StoreData  in  XLEN  store data (rs2 value)
flush  in  1  kill the instruction currently in EX/MEM
mem_rdata  in  XLEN  memory read data
mem_ack  in  1  memory completes the access this cycle
mem_req  out  1  access request
mem_we  out  1  1 = store, 0 = load
mem_addr  out  XLEN  access address
mem_wdata  out  XLEN  store data
stall  out  1  upstream must hold EX/MEM and earlier stages
MEM_WB_Valid  out  1  MEM/WB holds a real instruction
MEM_WB_RegWrite  out  1  writeback enable
MEM_WB_MemRead  out  1  result selected from MEM_WB_MemOut
MEM_WB_RegisterRd  out  RA_W  writeback register
MEM_WB_ALUOut  out  XLEN  registered ALU result
MEM_WB_MemOut  out  XLEN  registered load data

Behaviour:
- Reset (asynchronous, rst=1): state IDLE. Every registered output is 0, including mem_req, mem_we, mem_addr, mem_wdata and all MEM_WB_*.
- Reset mid-access: the access is abandoned, no writeback occurs, and a late mem_ack is ignored.
- Input qualification:
  - in_valid = EX_MEM_Valid & !flush.
  - mem_op = in_valid & (EX_MEM_MemRead | EX_MEM_MemWrite).
  - MemRead and MemWrite both 1 is illegal; the block treats it as a load.
- State IDLE, no mem_op: at the next edge MEM/WB captures the EX/MEM fields.
  - MEM_WB_Valid = in_valid.
  - MEM_WB_RegWrite = in_valid & EX_MEM_RegWrite & (Rd != 0).
  - MEM_WB_MemRead = 0. MEM_WB_MemOut holds its previous value.
  - Latency: 1 cycle.
- State IDLE, mem_op:
  - stall = 1 (combinational).
  - Next edge: latch mem_addr = ALUOut, mem_wdata = StoreData, mem_we = MemWrite, and the rd/RegWrite/MemRead controls into holding registers.
  - Set mem_req = 1 and go to ACCESS.
  - MEM/WB is loaded with a bubble (Valid = 0, RegWrite = 0, MemRead = 0).
- State ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - stall = !mem_ack.
  - Each cycle without ack loads a bubble into MEM/WB.
- On the mem_ack cycle, at the next edge:
  - MEM_WB_MemOut = mem_rdata (loads only; stores leave it unchanged).
  - MEM_WB_ALUOut = latched address.
  - MEM_WB_RegisterRd = latched rd. MEM_WB_RegWrite = latched RegWrite & (rd != 0).
  - MEM_WB_MemRead = latched MemRead. MEM_WB_Valid = 1.
  - mem_req = 0 and state returns to IDLE.
- Because stall drops during the ack cycle, the upstream advances at the same edge. The next instruction is evaluated in IDLE on the following cycle.
- Load latency: N+1 cycles, where mem_ack arrives N cycles after mem_req rises (N ≥ 1; ack in the first ACCESS cycle gives 2 cycles).
- A store never produces RegWrite = 1, regardless of EX_MEM_RegWrite.
- flush:
  - Acts only on the instruction sampled in IDLE.
  - In ACCESS it is ignored: the in-flight access completes and writes back.
- mem_ack while in IDLE is ignored.
- stall is purely combinational from state, inputs and mem_ack. It never depends on MEM_WB_*.
- Write-to-rd 0 never reaches MEM_WB_RegWrite = 1.

Test Plan:
- Reset, then three ALU ops (rd = 5, 6, 0; RegWrite = 1): each appears on MEM/WB one cycle later with MemRead = 0. RegWrite = 1, 1, 0 respectively; stall stays 0.
- Load, addr 0x100, rd = 7, ack 3 cycles after req: stall high for 3 cycles, mem_req held, MEM/WB bubbles. Then MEM_WB_RegWrite = 1, MEM_WB_MemRead = 1, Rd = 7, MemOut = mem_rdata (0xDEADBEEF).
- Store, addr 0x20, data 0x55, ack on the first ACCESS cycle: mem_we = 1, mem_wdata = 0x55. Stall lasts 1 cycle, MEM_WB_RegWrite = 0, MEM_WB_Valid = 1.
- flush with a load in IDLE: no mem_req, stall = 0, MEM/WB bubble. flush asserted during ACCESS: access still completes and writes back.
- Back-to-back loads (rd = 3, then rd = 4, ack delay 1): two separate requests, MEM/WB outputs rd = 3 then rd = 4. mem_req deasserted for at least one cycle between them.
- Assert rst during ACCESS, then pulse mem_ack after release: all outputs 0, state IDLE, no writeback.
